// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM pipeline register with valid/ready handshake; all state changes on the falling clock edge.
// Define EXE_MEM_PIPE_REG_SKID_EN for a two-entry (main + skid) buffer with a registered ready_e.
module exe_mem_pipe_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_e,
  output logic                  ready_e,
  input  logic                  regWrite_e,
  input  logic                  memToReg_e,
  input  logic                  memWrite_e,
  input  logic [DATA_W-1:0]     alu_out_e,
  input  logic [DATA_W-1:0]     write_data_e,
  input  logic [REG_ADDR_W-1:0] write_reg_e,
  input  logic                  flush,
  output logic                  valid_m,
  input  logic                  ready_m,
  output logic                  regWrite_m,
  output logic                  memToReg_m,
  output logic                  memWrite_m,
  output logic [DATA_W-1:0]     alu_out_m,
  output logic [DATA_W-1:0]     write_data_m,
  output logic [REG_ADDR_W-1:0] write_reg_m,
  output logic [CNT_W-1:0]      bubble_cnt
);

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  mem_write;
    logic [DATA_W-1:0]     alu_out;
    logic [DATA_W-1:0]     write_data;
    logic [REG_ADDR_W-1:0] write_reg;
  } entry_t;

  // Clearing the control bits when an entry retires keeps bubbles harmless while data holds.
  function automatic entry_t kill_ctrl(input entry_t e);
    entry_t k;
    k            = e;
    k.reg_write  = 1'b0;
    k.mem_to_reg = 1'b0;
    k.mem_write  = 1'b0;
    return k;
  endfunction

  entry_t           in_s;
  entry_t           main_r;
  entry_t           main_nxt_s;
  logic             valid_r;
  logic             valid_nxt_s;
  logic             in_xfer_s;
  logic             out_xfer_s;
  logic [CNT_W-1:0] bubble_cnt_r;

  assign in_s       = {regWrite_e, memToReg_e, memWrite_e, alu_out_e, write_data_e, write_reg_e};
  assign in_xfer_s  = valid_e & ready_e;
  assign out_xfer_s = valid_r & ready_m;

`ifdef EXE_MEM_PIPE_REG_SKID_EN
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    MAIN  = 2'b01,
    FULL  = 2'b10
  } state_t;

  state_t state_r;
  state_t state_nxt_s;
  entry_t skid_r;
  entry_t skid_nxt_s;
  logic   ready_r;
  logic   ready_nxt_s;

  // ready_r resets high so the first edge after reset can accept; rst masks it meanwhile.
  assign ready_e = ready_r & ~rst;

  // FSM state register.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and entry-movement logic; flush wins over both transfers.
  always_comb begin
    state_nxt_s = state_r;
    main_nxt_s  = main_r;
    skid_nxt_s  = skid_r;
    if (flush) begin
      state_nxt_s = EMPTY;
      main_nxt_s  = kill_ctrl(main_r);
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_xfer_s) begin
            state_nxt_s = MAIN;
            main_nxt_s  = in_s;
          end else begin
            state_nxt_s = EMPTY;
          end
        end
        MAIN: begin
          if (in_xfer_s && out_xfer_s) begin
            main_nxt_s = in_s;
          end else if (in_xfer_s) begin
            state_nxt_s = FULL;
            skid_nxt_s  = in_s;
          end else if (out_xfer_s) begin
            state_nxt_s = EMPTY;
            main_nxt_s  = kill_ctrl(main_r);
          end else begin
            state_nxt_s = MAIN;
          end
        end
        FULL: begin
          if (out_xfer_s) begin
            state_nxt_s = MAIN;
            main_nxt_s  = skid_r;
          end else begin
            state_nxt_s = FULL;
          end
        end
        default: begin
          state_nxt_s = EMPTY;
          main_nxt_s  = kill_ctrl(main_r);
        end
      endcase
    end
    valid_nxt_s = (state_nxt_s != EMPTY);
    ready_nxt_s = (state_nxt_s != FULL);
  end

  // Skid entry and registered ready.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      skid_r  <= '0;
      ready_r <= 1'b1;
    end else begin
      skid_r  <= skid_nxt_s;
      ready_r <= ready_nxt_s;
    end
  end
`else
  // Single entry: accept when empty or when the current entry leaves this edge.
  assign ready_e = ~rst & (~valid_r | ready_m);

  // Next-entry logic for the single-entry register; flush wins over both transfers.
  always_comb begin
    main_nxt_s  = main_r;
    valid_nxt_s = valid_r;
    if (flush) begin
      valid_nxt_s = 1'b0;
      main_nxt_s  = kill_ctrl(main_r);
    end else if (in_xfer_s) begin
      valid_nxt_s = 1'b1;
      main_nxt_s  = in_s;
    end else if (out_xfer_s) begin
      valid_nxt_s = 1'b0;
      main_nxt_s  = kill_ctrl(main_r);
    end else begin
      valid_nxt_s = valid_r;
    end
  end
`endif

  // Output-facing entry register.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      main_r  <= '0;
      valid_r <= 1'b0;
    end else begin
      main_r  <= main_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  // Saturating count of edges that saw no valid output.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_r <= '0;
    end else if (!valid_r && (bubble_cnt_r != {CNT_W{1'b1}})) begin
      bubble_cnt_r <= bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      bubble_cnt_r <= bubble_cnt_r;
    end
  end

  assign valid_m      = valid_r;
  assign regWrite_m   = main_r.reg_write;
  assign memToReg_m   = main_r.mem_to_reg;
  assign memWrite_m   = main_r.mem_write;
  assign alu_out_m    = main_r.alu_out;
  assign write_data_m = main_r.write_data;
  assign write_reg_m  = main_r.write_reg;
  assign bubble_cnt   = bubble_cnt_r;

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Directed bench for exe_mem_pipe_reg; expectations follow EXE_MEM_PIPE_REG_SKID_EN when defined.
module tb_exe_mem_pipe_reg;

  logic        clk;
  logic        rst;
  logic        valid_e;
  logic        ready_e;
  logic        regWrite_e;
  logic        memToReg_e;
  logic        memWrite_e;
  logic [31:0] alu_out_e;
  logic [31:0] write_data_e;
  logic [4:0]  write_reg_e;
  logic        flush;
  logic        valid_m;
  logic        ready_m;
  logic        regWrite_m;
  logic        memToReg_m;
  logic        memWrite_m;
  logic [31:0] alu_out_m;
  logic [31:0] write_data_m;
  logic [4:0]  write_reg_m;
  logic [15:0] bubble_cnt;

  logic        s_ready_e;
  logic        s_valid_m;
  logic        s_regWrite_m;
  logic        s_memToReg_m;
  logic        s_memWrite_m;
  logic [31:0] s_alu_out_m;
  logic [31:0] s_write_data_m;
  logic [4:0]  s_write_reg_m;
  logic [3:0]  s_bubble_cnt;

  int n_vec = 0;
  int n_err = 0;

  exe_mem_pipe_reg dut (
    .clk(clk), .rst(rst), .valid_e(valid_e), .ready_e(ready_e),
    .regWrite_e(regWrite_e), .memToReg_e(memToReg_e), .memWrite_e(memWrite_e),
    .alu_out_e(alu_out_e), .write_data_e(write_data_e), .write_reg_e(write_reg_e),
    .flush(flush), .valid_m(valid_m), .ready_m(ready_m),
    .regWrite_m(regWrite_m), .memToReg_m(memToReg_m), .memWrite_m(memWrite_m),
    .alu_out_m(alu_out_m), .write_data_m(write_data_m), .write_reg_m(write_reg_m),
    .bubble_cnt(bubble_cnt)
  );

  // Narrow-counter instance for the saturation check.
  exe_mem_pipe_reg #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .valid_e(valid_e), .ready_e(s_ready_e),
    .regWrite_e(regWrite_e), .memToReg_e(memToReg_e), .memWrite_e(memWrite_e),
    .alu_out_e(alu_out_e), .write_data_e(write_data_e), .write_reg_e(write_reg_e),
    .flush(flush), .valid_m(s_valid_m), .ready_m(ready_m),
    .regWrite_m(s_regWrite_m), .memToReg_m(s_memToReg_m), .memWrite_m(s_memWrite_m),
    .alu_out_m(s_alu_out_m), .write_data_m(s_write_data_m), .write_reg_m(s_write_reg_m),
    .bubble_cnt(s_bubble_cnt)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] alu, input logic [4:0] wreg, input logic rw, input logic mw);
    valid_e     = 1'b1;
    alu_out_e   = alu;
    write_reg_e = wreg;
    regWrite_e  = rw;
    memWrite_e  = mw;
  endtask

  initial begin
    rst = 1'b1; valid_e = 1'b0; regWrite_e = 1'b0; memToReg_e = 1'b0; memWrite_e = 1'b0;
    alu_out_e = 32'h0; write_data_e = 32'h0; write_reg_e = 5'd0; flush = 1'b0; ready_m = 1'b0;
    #2;
    check("rst_valid_m", valid_m, 1'b0);
    check("rst_regWrite_m", regWrite_m, 1'b0);
    check("rst_alu_out_m", alu_out_m, 32'h0);
    check("rst_bubble_cnt", bubble_cnt, 16'd0);
    check("rst_ready_e", ready_e, 1'b0);
    #5;
    rst = 1'b0;
    #1;
    check("post_rst_ready_e", ready_e, 1'b1);

    // Pass-through
    ready_m = 1'b1; offer(32'h0000_00A5, 5'd7, 1'b1, 1'b0);
    write_data_e = 32'h0000_1234; memToReg_e = 1'b1;
    tick();
    check("pt_valid_m", valid_m, 1'b1);
    check("pt_alu_out_m", alu_out_m, 32'h0000_00A5);
    check("pt_write_reg_m", write_reg_m, 5'd7);
    check("pt_regWrite_m", regWrite_m, 1'b1);
    check("pt_memToReg_m", memToReg_m, 1'b1);
    check("pt_write_data_m", write_data_m, 32'h0000_1234);
    check("pt_bubble_cnt", bubble_cnt, 16'd1);
    valid_e = 1'b0; memToReg_e = 1'b0;
    tick();
    check("drain_valid_m", valid_m, 1'b0);
    check("drain_regWrite_m", regWrite_m, 1'b0);
    check("drain_memToReg_m", memToReg_m, 1'b0);
    check("drain_alu_hold", alu_out_m, 32'h0000_00A5);
    check("drain_wreg_hold", write_reg_m, 5'd7);
    check("drain_bubble_cnt", bubble_cnt, 16'd1);

    // Backpressure: A, B, C offered with the memory stage stalled
    ready_m = 1'b0; offer(32'h11, 5'd1, 1'b0, 1'b0);
`ifdef EXE_MEM_PIPE_REG_SKID_EN
    tick();
    check("bp_a_ready_e", ready_e, 1'b1);
    offer(32'h22, 5'd2, 1'b0, 1'b0);
    tick();
    check("bp_full_ready_e", ready_e, 1'b0);
    check("bp_a_alu", alu_out_m, 32'h11);
    offer(32'h33, 5'd3, 1'b0, 1'b0);
    tick();
    check("bp_hold_alu", alu_out_m, 32'h11);
    check("bp_hold_wreg", write_reg_m, 5'd1);
    check("bp_hold_ready_e", ready_e, 1'b0);
    ready_m = 1'b1;
    tick();
    check("bp_out_b", alu_out_m, 32'h22);
    tick();
    check("bp_out_c", alu_out_m, 32'h33);
    check("bp_out_c_wreg", write_reg_m, 5'd3);
    valid_e = 1'b0;
    tick();
    check("bp_empty", valid_m, 1'b0);
`else
    tick();
    check("bp_a_ready_e", ready_e, 1'b0);
    check("bp_a_alu", alu_out_m, 32'h11);
    offer(32'h22, 5'd2, 1'b0, 1'b0);
    tick();
    check("bp_hold_alu", alu_out_m, 32'h11);
    check("bp_hold_ready_e", ready_e, 1'b0);
    ready_m = 1'b1;
    #1;
    check("bp_comb_ready_e", ready_e, 1'b1);
    tick();
    check("bp_out_b", alu_out_m, 32'h22);
    offer(32'h33, 5'd3, 1'b0, 1'b0);
    tick();
    check("bp_out_c", alu_out_m, 32'h33);
    check("bp_out_c_wreg", write_reg_m, 5'd3);
    valid_e = 1'b0;
    tick();
    check("bp_empty", valid_m, 1'b0);
`endif

    // Flush drops held entry and the simultaneous input
    ready_m = 1'b0; offer(32'h44, 5'd4, 1'b0, 1'b1);
    tick();
    check("fl_pre_valid_m", valid_m, 1'b1);
    check("fl_pre_memWrite_m", memWrite_m, 1'b1);
    offer(32'h55, 5'd5, 1'b0, 1'b1); flush = 1'b1;
    tick();
    check("fl_valid_m", valid_m, 1'b0);
    check("fl_memWrite_m", memWrite_m, 1'b0);
    flush = 1'b0; valid_e = 1'b0; memWrite_e = 1'b0; ready_m = 1'b1;
    tick();
    check("fl_no_ghost_valid", valid_m, 1'b0);
    check("fl_no_ghost_alu", alu_out_m, 32'h44);

    // Reset between edges with entries held
    ready_m = 1'b0; offer(32'h66, 5'd6, 1'b1, 1'b0);
    tick();
    offer(32'h77, 5'd8, 1'b1, 1'b0);
    tick();
    valid_e = 1'b0;
    #2; rst = 1'b1;
    #1;
    check("mr_valid_m", valid_m, 1'b0);
    check("mr_bubble_cnt", bubble_cnt, 16'd0);
    check("mr_regWrite_m", regWrite_m, 1'b0);
    check("mr_alu_out_m", alu_out_m, 32'h0);
    check("mr_ready_e", ready_e, 1'b0);
    rst = 1'b0;
    offer(32'h88, 5'd9, 1'b1, 1'b0);
    #1;
    check("mr_post_ready_e", ready_e, 1'b1);
    tick();
    check("mr_new_valid", valid_m, 1'b1);
    check("mr_new_alu", alu_out_m, 32'h88);
    check("mr_new_regWrite", regWrite_m, 1'b1);
    valid_e = 1'b0; regWrite_e = 1'b0;

    // Saturation of the 4-bit counter over idle edges
    #2; rst = 1'b1; #1; rst = 1'b0; ready_m = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("sat_cnt4", s_bubble_cnt, 4'd15);
    check("sat_cnt16", bubble_cnt, 16'd20);
    for (int i = 0; i < 3; i++) tick();
    check("sat_cnt4_stays", s_bubble_cnt, 4'd15);
    check("sat_cnt16_more", bubble_cnt, 16'd23);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exe_mem_pipe_reg.md
EXE_MEM_PIPE_REG -- requirements
Module: exe_mem_pipe_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of ALU result and store data.
REQ-002 SHALL have parameter REG_ADDR_W, default 5, width of destination register index.
REQ-003 SHALL have parameter CNT_W, default 16, width of bubble counter.
REQ-004 clk  input  1  sole clock; all state SHALL update on its falling edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 valid_e  input  1  execute stage presents a valid instruction.
REQ-007 ready_e  output  1  block accepts from execute stage this cycle.
REQ-008 regWrite_e, memToReg_e, memWrite_e  input  1 each  execute-stage control bits.
REQ-009 alu_out_e, write_data_e  input  DATA_W each  ALU result, store data.
REQ-010 write_reg_e  input  REG_ADDR_W  destination register index.
REQ-011 flush  input  1  synchronous squash of all held entries.
REQ-012 valid_m  output  1  memory stage sees a valid instruction.
REQ-013 ready_m  input  1  memory stage consumes this cycle.
REQ-014 regWrite_m, memToReg_m, memWrite_m, alu_out_m, write_data_m, write_reg_m  output  widths as inputs  memory-stage copies.
REQ-015 bubble_cnt  output  CNT_W  count of falling edges with valid_m=0.

Function
REQ-016 Input transfer SHALL occur on a falling edge with valid_e=1 and ready_e=1; output transfer on a falling edge with valid_m=1 and ready_m=1.
REQ-017 Accepted entries SHALL leave in acceptance order, unmodified, none lost or duplicated.
REQ-018 Latency SHALL be exactly one falling edge from input transfer to valid_m=1 when the block is empty.
REQ-019 With valid_m=1 and ready_m=0, all *_m outputs SHALL hold stable.
REQ-020 regWrite_m, memToReg_m, memWrite_m SHALL be forced 0 whenever valid_m=0, so a bubble never writes.
REQ-021 alu_out_m, write_data_m, write_reg_m SHALL hold their last value while valid_m=0.
REQ-022 flush=1 SHALL clear all entry valids at that edge and drop any simultaneous input transfer; flush overrides input and output transfer.
REQ-023 ready_e SHALL remain functionally correct during flush (any value allowed; transfer still dropped).
REQ-024 bubble_cnt SHALL increment on each falling edge where valid_m=0 (pre-edge value), saturate at 2^CNT_W-1, never wrap.
REQ-025 Simultaneous input and output transfer on one edge SHALL both complete (throughput one per cycle).

Reset
REQ-026 rst=1 SHALL immediately, without a clock edge, force valid_m=0, all control outputs 0, alu_out_m/write_data_m/write_reg_m to 0, bubble_cnt 0, and empty all entries.
REQ-027 rst asserted mid-transfer SHALL discard all held entries; first acceptance is possible on the first falling edge after rst deasserts.
REQ-028 During rst, ready_e SHALL read 0.

Configuration
REQ-029 Macro EXE_MEM_PIPE_REG_SKID_EN SHALL select buffering.
REQ-030 Defined: two entries (main, skid), states EMPTY, MAIN, FULL; ready_e SHALL be a register output, 1 unless FULL.
REQ-031 Defined transitions: EMPTY->MAIN on input; MAIN->FULL on input without output; MAIN->EMPTY on output without input; FULL->MAIN on output (skid moves to main); flush -> EMPTY.
REQ-032 Undefined: one entry; ready_e = !valid_m | ready_m combinationally; no skid storage.

Verification
REQ-033 Pass-through: ready_m=1, valid_e=1, alu_out_e=0x000000A5, write_reg_e=7, regWrite_e=1 -> next falling edge valid_m=1, alu_out_m=0x000000A5, write_reg_m=7, regWrite_m=1.
REQ-034 Backpressure (SKID_EN): ready_m=0, offer A=0x11, B=0x22, C=0x33 -> A, B accepted, ready_e=0, C held; ready_m=1 -> outputs 0x11, 0x22, 0x33 in order, one per cycle.
REQ-035 Flush: valid_m=1, memWrite_m=1, assert flush with valid_e=1 -> next edge valid_m=0, memWrite_m=0, incoming entry never appears.
REQ-036 Reset mid-operation: two entries held, pulse rst between edges -> valid_m=0, bubble_cnt=0 immediately; new entry emerges after one edge post-reset.
REQ-037 Saturation: CNT_W=4, 20 idle falling edges -> bubble_cnt=15, stays 15.
